cpu_phase_ctrl: RTL and testbench
=================================

Name: cpu_phase_ctrl

Overview:
- Parametrised multi-cycle sequencer that replaces the single fetch/execute toggle bit in the CPU top.
- Sequences FETCH → DECODE → EXECUTE → MEM → WRITEBACK over a variable-latency req/ack memory port, such as the LPDDR2 bridge.
- Owns the PC, instruction register and memory data register, and gates GPR writes to a one-cycle writeback strobe.
- Detects memory timeouts and illegal read/write conflicts, then halts.

Parameters:
- ADDR_W, 32, byte-address and PC width.
- DATA_W, 32, instruction and data word width.
- RESET_PC, 32'h0, PC value after reset.
- TIMEOUT, 255, maximum cycles spent in a wait state before the block faults (1..2^16-1).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- ena  in  1  run enable; sampled only in FETCH.
- next_pc  in  ADDR_W  next PC from the decode stage.
- alu_res  in  ADDR_W  effective byte address for loads and stores.
- store_data  in  DATA_W  store data (rt).
- dec_rren  in  1  decoder: instruction is a load.
- dec_wren  in  1  decoder: instruction is a store.
- dec_gp_we  in  1  decoder: instruction writes a GPR.
- mem_req  out  1  memory request; held high until ack.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W-2  word address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid on the ack cycle.
- mem_ack  in  1  one-cycle completion pulse.
- pc  out  ADDR_W  current PC.
- instr  out  DATA_W  instruction register.
- mdr  out  DATA_W  load data register.
- gpr_we  out  1  GPR write strobe.
- phase  out  3  current state encoding.
- retired  out  32  retired-instruction counter.
- err  out  2  fault code: 0 none, 1 timeout, 2 rd/wr conflict.

Behaviour:
- Reset values:
  - State FETCH; pc=RESET_PC.
  - instr=0, mdr=0, retired=0, err=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, gpr_we=0.
- All outputs are registered.
- FETCH:
  - ena=1: assert mem_req, mem_we=0, mem_addr=pc[ADDR_W-1:2]; go to FETCH_WAIT.
  - ena=0: stay in FETCH with all strobes low.
- FETCH_WAIT:
  - mem_ack=1: capture instr<=mem_rdata, drop mem_req on the next edge, go to DECODE.
- DECODE: single settle cycle for the combinational decode path; go to EXECUTE.
- EXECUTE:
  - dec_rren&dec_wren: go to HALT with err=2.
  - dec_rren|dec_wren: assert mem_req, mem_we=dec_wren, mem_addr=alu_res[ADDR_W-1:2], mem_wdata=store_data; go to MEM_WAIT.
  - Neither: go to WRITEBACK.
- MEM_WAIT:
  - mem_ack=1: on a read, mdr<=mem_rdata; drop mem_req; go to WRITEBACK.
- WRITEBACK:
  - gpr_we=dec_gp_we for exactly this cycle.
  - pc<=next_pc; retired<=retired+1, wrapping at 2^32.
  - Go to FETCH.
- Latency:
  - Minimum 5 cycles per ALU instruction (ack on the first wait cycle).
  - Minimum 6 cycles per load or store.
  - Each extra wait cycle adds 1.
- Timeout:
  - A wait counter clears on entry to each wait state and increments on every wait cycle without ack.
  - When the count reaches TIMEOUT: go to HALT with err=1 and mem_req=0.
  - Ack on the same cycle as the count reaching TIMEOUT: the ack wins.
- HALT: sticky; all strobes low; pc, instr and err hold; only rst exits.
- Ignored inputs:
  - mem_ack outside a wait state is ignored.
  - ena is ignored after FETCH, so an instruction in flight always completes.
- mem_addr, mem_we and mem_wdata are stable for the whole request.
- rst asserted mid-transaction aborts immediately to the reset values. The memory side must tolerate the dropped req.

Optional Feature:
- Macro CPU_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - FETCH leaves only when ena=1 and a rising edge of step has been latched.
  - The latch is consumed on leaving FETCH, so exactly one instruction retires per step edge.
  - Extra edges while busy are merged into one pending step.
- When undefined: the step port is absent and the block free-runs under ena.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - phase_e enum: FETCH=0, FETCH_WAIT, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, HALT.
  - err_e enum: ERR_NONE, ERR_TIMEOUT, ERR_RWCONF.
  - Default width constants.
- Sub-module mem_wait_timer (clear, count, expired output), parametrised by TIMEOUT.

Test Plan:
- ALU stream:
  - Stimulus: ena=1, ack 1 cycle after req, instr 32'h00221820, dec_gp_we=1, next_pc=pc+4.
  - Response: 5 cycles per instruction; gpr_we is a single pulse; pc goes 0→4→8; retired=3 after 15 cycles.
- Load with 7-cycle ack latency:
  - Stimulus: alu_res=32'h100, rdata=32'hDEADBEEF.
  - Response: mem_addr=32'h40 stable for the whole request; mdr=32'hDEADBEEF; total 12 cycles.
- Store:
  - Stimulus: store_data=32'h12345678.
  - Response: mem_we=1, mem_wdata=32'h12345678; gpr_we=0 when dec_gp_we=0.
- Timeout:
  - Stimulus: TIMEOUT=4, no ack.
  - Response: HALT with err=1 and mem_req=0 after 4 wait cycles; a late ack is ignored; rst restores pc=RESET_PC.
- Conflict:
  - Stimulus: dec_rren=dec_wren=1 in EXECUTE.
  - Response: err=2, HALT, no req issued.
- ena dropped mid-instruction, and rst during MEM_WAIT:
  - ena=0 mid-instruction: the instruction completes, then the block holds in FETCH.
  - rst during MEM_WAIT: all outputs return to reset values immediately.

Source files
------------

// File: rtl/cpu_phase_ctrl_pkg.sv
// Shared phase/fault encodings and default widths for the multi-cycle CPU sequencer.
package cpu_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned TIMER_W    = 16;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    FETCH_WAIT = 3'd1,
    DECODE     = 3'd2,
    EXECUTE    = 3'd3,
    MEM_WAIT   = 3'd4,
    WRITEBACK  = 3'd5,
    HALT       = 3'd6
  } phase_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_RWCONF  = 2'd2
  } err_e;

endpackage

// File: rtl/cpu_phase_ctrl_mem_wait_timer.sv
// Wait-state watchdog: counts ack-less wait cycles and flags the cycle on which
// the TIMEOUT-th such cycle completes.
module mem_wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  // Asserted during the wait cycle that would bring the count to TIMEOUT.
  assign expired = count && (cnt == LAST);

endmodule

// File: rtl/cpu_phase_ctrl.sv
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer over a req/ack memory port.
// Define CPU_SINGLE_STEP_EN to add the step input (one instruction per step edge).
module cpu_phase_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CPU_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic              ena,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic [DATA_W-1:0] store_data,
  input  logic              dec_rren,
  input  logic              dec_wren,
  input  logic              dec_gp_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              gpr_we,
  output logic [2:0]        phase,
  output logic [31:0]       retired,
  output logic [1:0]        err
);

  phase_e state;
  err_e   err_q;
  logic   go;
  logic   in_wait;
  logic   expired;
  logic   unused_bits;

  assign unused_bits = ^alu_res[1:0];
  assign in_wait     = (state == FETCH_WAIT) || (state == MEM_WAIT);
  assign phase       = state;
  assign err         = err_q;

`ifdef CPU_SINGLE_STEP_EN
  logic step_q;
  logic step_pend;
  logic step_edge;

  assign step_edge = step & ~step_q;
  assign go        = ena & step_pend;

  // A fresh edge arriving on the consuming cycle stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q <= step;
      if (state == FETCH && go) begin
        step_pend <= step_edge;
      end else if (step_edge) begin
        step_pend <= 1'b1;
      end
    end
  end
`else
  assign go = ena;
`endif

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait),
    .count   (in_wait && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      err_q     <= ERR_NONE;
      pc        <= RESET_PC;
      instr     <= '0;
      mdr       <= '0;
      retired   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      gpr_we    <= 1'b0;
    end else begin
      gpr_we <= 1'b0;
      case (state)
        FETCH: begin
          if (go) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc[ADDR_W-1:2];
            state    <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (mem_ack) begin
            instr   <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DECODE;
          end else if (expired) begin
            mem_req <= 1'b0;
            err_q   <= ERR_TIMEOUT;
            state   <= HALT;
          end
        end
        DECODE: state <= EXECUTE;
        EXECUTE: begin
          if (dec_rren && dec_wren) begin
            err_q <= ERR_RWCONF;
            state <= HALT;
          end else if (dec_rren || dec_wren) begin
            mem_req   <= 1'b1;
            mem_we    <= dec_wren;
            mem_addr  <= alu_res[ADDR_W-1:2];
            mem_wdata <= store_data;
            state     <= MEM_WAIT;
          end else begin
            gpr_we <= dec_gp_we;
            state  <= WRITEBACK;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            if (!mem_we) mdr <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            gpr_we  <= dec_gp_we;
            state   <= WRITEBACK;
          end else if (expired) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err_q   <= ERR_TIMEOUT;
            state   <= HALT;
          end
        end
        WRITEBACK: begin
          pc      <= next_pc;
          retired <= retired + 32'd1;
          state   <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Scoreboard bench for cpu_phase_ctrl: a latency-programmable memory model plus
// expected request/retire queues, and a second instance built with TIMEOUT=4.
module tb_cpu_phase_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic [AW-1:0] next_pc, alu_res = '0;
  logic [DW-1:0] store_data = '0;
  logic          dec_rren = 1'b0, dec_wren = 1'b0, dec_gp_we = 1'b0;
  logic          mem_req, mem_we, mem_ack = 1'b0;
  logic [AW-3:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr, mdr;
  logic          gpr_we;
  logic [2:0]    phase;
  logic [31:0]   retired;
  logic [1:0]    err;

  assign next_pc = pc + 32'd4;

  cpu_phase_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'h0), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .ena(ena), .next_pc(next_pc), .alu_res(alu_res),
    .store_data(store_data), .dec_rren(dec_rren), .dec_wren(dec_wren),
    .dec_gp_we(dec_gp_we), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc),
    .instr(instr), .mdr(mdr), .gpr_we(gpr_we), .phase(phase), .retired(retired),
    .err(err)
  );

  logic          t_ena = 1'b0, t_mem_ack = 1'b0;
  logic [AW-1:0] t_next_pc, t_alu_res = '0;
  logic [DW-1:0] t_store_data = '0, t_mem_rdata = '0;
  logic          t_dec_rren = 1'b0, t_dec_wren = 1'b0, t_dec_gp_we = 1'b0;
  logic          t_mem_req, t_mem_we, t_gpr_we;
  logic [AW-3:0] t_mem_addr;
  logic [DW-1:0] t_mem_wdata, t_instr, t_mdr;
  logic [AW-1:0] t_pc;
  logic [2:0]    t_phase;
  logic [31:0]   t_retired;
  logic [1:0]    t_err;

  assign t_next_pc = t_pc + 32'd4;

  cpu_phase_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'h1000), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .ena(t_ena), .next_pc(t_next_pc), .alu_res(t_alu_res),
    .store_data(t_store_data), .dec_rren(t_dec_rren), .dec_wren(t_dec_wren),
    .dec_gp_we(t_dec_gp_we), .mem_req(t_mem_req), .mem_we(t_mem_we),
    .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_rdata(t_mem_rdata),
    .mem_ack(t_mem_ack), .pc(t_pc), .instr(t_instr), .mdr(t_mdr), .gpr_we(t_gpr_we),
    .phase(t_phase), .retired(t_retired), .err(t_err)
  );

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-3:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic [DW-1:0] mdr;
    logic          gpr_we;
    logic [31:0]   retired;
    int unsigned   lat;
  } ret_t;

  req_t req_q[$];
  ret_t ret_q[$];

  logic [AW-1:0] m_pc = '0;
  logic [DW-1:0] m_mdr = '0;
  logic [31:0]   m_ret = '0;
  logic [DW-1:0] instr_word = 32'h00221820, load_word = '0;
  int unsigned   lat_f = 1, lat_m = 1;
  int unsigned   cyc = 0, last_wb = 0;
  int unsigned   stray = 0, unstable = 0, unexpected = 0;

  // Memory model: acks the lat-th wait cycle of each request.
  initial begin
    int unsigned wcnt = 0;
    int unsigned lat;
    req_t cur, held;
    forever begin
      @(posedge clk); #1;
      if (rst || !mem_req) begin
        wcnt = 0;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end else begin
        wcnt++;
        if (wcnt == 1) begin
          if (req_q.size() == 0) begin
            unexpected++;
          end else begin
            cur = req_q.pop_front();
            check("req_addr", 32'(mem_addr), 32'(cur.addr));
            check("req_we", 32'(mem_we), 32'(cur.we));
            if (cur.we) check("req_wdata", mem_wdata, cur.wdata);
          end
          held = '{addr: mem_addr, we: mem_we, wdata: mem_wdata};
        end else if (mem_addr !== held.addr || mem_we !== held.we || mem_wdata !== held.wdata) begin
          unstable++;
        end
        lat = (phase == FETCH_WAIT) ? lat_f : lat_m;
        if (wcnt == lat) begin
          mem_ack = 1'b1;
          mem_rdata = (phase == FETCH_WAIT) ? instr_word : load_word;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Retirement monitor: one record per WRITEBACK cycle.
  initial begin
    ret_t r;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst) begin
        if (gpr_we && phase != WRITEBACK) stray++;
        if (phase == WRITEBACK) begin
          if (ret_q.size() == 0) begin
            unexpected++;
          end else begin
            r = ret_q.pop_front();
            check("wb_pc", pc, r.pc);
            check("wb_instr", instr, r.instr);
            check("wb_mdr", mdr, r.mdr);
            check("wb_gpr_we", 32'(gpr_we), 32'(r.gpr_we));
            check("wb_retired", retired, r.retired);
            if (r.lat != 0) check("wb_cycles", cyc - last_wb, r.lat);
          end
          last_wb = cyc;
        end
      end
    end
  end

  task automatic push_instrs(input int unsigned n, input logic rr, input logic wr, input logic gw);
    int unsigned exp_lat;
    dec_rren = rr; dec_wren = wr; dec_gp_we = gw;
    exp_lat = 4 + lat_f + ((rr || wr) ? lat_m : 0);
    for (int unsigned i = 0; i < n; i++) begin
      req_q.push_back('{addr: m_pc[AW-1:2], we: 1'b0, wdata: '0});
      if (rr || wr) req_q.push_back('{addr: alu_res[AW-1:2], we: wr, wdata: store_data});
      if (rr) m_mdr = load_word;
      ret_q.push_back('{pc: m_pc, instr: instr_word, mdr: m_mdr, gpr_we: gw,
                        retired: m_ret, lat: (i == 0) ? 0 : exp_lat});
      m_pc += 32'd4;
      m_ret += 32'd1;
    end
  endtask

  task automatic wait_empty(input string tag);
    int unsigned k = 0;
    while (ret_q.size() != 0 && k < 300) begin
      @(posedge clk); #2;
      k++;
    end
    check(tag, ret_q.size(), 0);
  endtask

  task automatic wait_phase(input logic [2:0] p, input string tag);
    int unsigned k = 0;
    while (phase !== p && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'(phase), 32'(p));
  endtask

  task automatic run_seg(input int unsigned n, input logic rr, input logic wr, input logic gw, input string tag);
    push_instrs(n, rr, wr, gw);
    ena = 1'b1;
    wait_empty(tag);
    ena = 1'b0;
    @(posedge clk); #1;
    check("seg_pc", pc, m_pc);
    check("seg_retired", retired, m_ret);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ena = 1'b0; t_ena = 1'b0;
    @(negedge clk); @(negedge clk);
    req_q.delete(); ret_q.delete();
    m_pc = '0; m_mdr = '0; m_ret = '0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_phase", 32'(phase), 32'(FETCH));
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_mdr", mdr, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_err", 32'(err), 32'(ERR_NONE));
    check("rst_req", 32'({mem_req, mem_we, gpr_we}), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_t_pc", t_pc, 32'h1000);

    // ALU stream, ack on first wait cycle
    lat_f = 1; lat_m = 1; instr_word = 32'h00221820;
    run_seg(3, 1'b0, 1'b0, 1'b1, "alu_done");

    // Loads with 7-cycle data latency
    alu_res = 32'h100; load_word = 32'hDEADBEEF; instr_word = 32'h8C430100; lat_m = 7;
    run_seg(2, 1'b1, 1'b0, 1'b1, "load_done");
    check("load_mdr", mdr, 32'hDEADBEEF);

    // Stores, no GPR write
    alu_res = 32'h204; store_data = 32'h12345678; instr_word = 32'hAC430204;
    lat_f = 2; lat_m = 3;
    run_seg(2, 1'b0, 1'b1, 1'b0, "store_done");

    // ena dropped mid-instruction: finishes, then idles in FETCH
    lat_f = 3; instr_word = 32'h00851020;
    push_instrs(1, 1'b0, 1'b0, 1'b1);
    ena = 1'b1;
    wait_phase(DECODE, "drop_reach_decode");
    ena = 1'b0;
    wait_empty("drop_done");
    repeat (6) @(posedge clk);
    #1;
    check("drop_idle_phase", 32'(phase), 32'(FETCH));
    check("drop_idle_req", 32'(mem_req), 32'h0);
    check("drop_retired", retired, m_ret);

    // rst asserted during MEM_WAIT
    lat_f = 1; lat_m = 100; alu_res = 32'h300;
    push_instrs(1, 1'b1, 1'b0, 1'b1);
    ena = 1'b1;
    wait_phase(MEM_WAIT, "mw_reach");
    ena = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mw_rst_phase", 32'(phase), 32'(FETCH));
    check("mw_rst_req", 32'({mem_req, mem_we}), 32'h0);
    check("mw_rst_pc", pc, 32'h0);
    check("mw_rst_regs", instr | mdr | retired, 32'h0);
    check("mw_rst_bus", 32'(mem_addr) | mem_wdata, 32'h0);
    do_reset();

    // Read/write conflict halts without a data request
    lat_f = 1; lat_m = 1; instr_word = 32'hFFFF0000;
    req_q.push_back('{addr: m_pc[AW-1:2], we: 1'b0, wdata: '0});
    dec_rren = 1'b1; dec_wren = 1'b1; dec_gp_we = 1'b1;
    ena = 1'b1;
    wait_phase(HALT, "conf_halt");
    ena = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("conf_err", 32'(err), 32'(ERR_RWCONF));
    check("conf_phase", 32'(phase), 32'(HALT));
    check("conf_req", 32'(mem_req), 32'h0);
    check("conf_pc", pc, 32'h0);
    check("conf_instr", instr, 32'hFFFF0000);
    check("conf_reqs_left", req_q.size(), 0);
    do_reset();
    dec_rren = 1'b0; dec_wren = 1'b0;

    // Timeout on the TIMEOUT=4 instance: one ALU instruction, then a fetch never acked
    t_ena = 1'b1;
    w = 0;
    while (!t_mem_req && w < 20) begin @(posedge clk); #1; w++; end
    check("to_first_addr", 32'(t_mem_addr), 32'h400);
    t_mem_rdata = 32'hCAFE0001; t_mem_ack = 1'b1;
    @(posedge clk); #1;
    t_mem_ack = 1'b0; t_mem_rdata = '0;
    w = 0;
    while (!t_mem_req && w < 20) begin @(posedge clk); #1; w++; end
    check("to_second_addr", 32'(t_mem_addr), 32'h401);
    w = 0;
    while (t_phase == FETCH_WAIT && w < 20) begin w++; @(posedge clk); #1; end
    check("to_wait_cycles", w, 4);
    check("to_phase", 32'(t_phase), 32'(HALT));
    check("to_err", 32'(t_err), 32'(ERR_TIMEOUT));
    check("to_req", 32'(t_mem_req), 32'h0);
    check("to_pc", t_pc, 32'h1004);
    check("to_retired", t_retired, 32'd1);
    t_mem_rdata = 32'h55AA55AA; t_mem_ack = 1'b1;
    @(posedge clk); #1;
    t_mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("to_late_phase", 32'(t_phase), 32'(HALT));
    check("to_late_instr", t_instr, 32'hCAFE0001);
    check("to_late_err", 32'(t_err), 32'(ERR_TIMEOUT));
    @(negedge clk);
    rst = 1'b1; t_ena = 1'b0;
    #1;
    check("to_rst_pc", t_pc, 32'h1000);
    check("to_rst_err", 32'(t_err), 32'(ERR_NONE));
    check("to_rst_phase", 32'(t_phase), 32'(FETCH));
    check("to_rst_regs", t_instr | t_mdr | t_retired | t_mem_wdata | 32'(t_mem_addr), 32'h0);
    check("to_rst_strobes", 32'({t_mem_req, t_mem_we, t_gpr_we}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    check("gpr_we_stray", stray, 0);
    check("req_unstable", unstable, 0);
    check("unexpected_events", unexpected, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
